// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared memory-interface definitions used by the memory arbiter and its
// requesters:
//   - arbiter state encoding (IDLE / LSB / IF / GAP)
//   - mc_len access-size codes (byte 000, half 001, word 010, bit 2 = signed)
//   - default instruction-line length in words
//   - helper for computing the address of a word inside a line
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LSB  = 2'd1;
    localparam logic [1:0] ST_IF   = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [2:0] LEN_BYTE = 3'b000;
    localparam logic [2:0] LEN_HALF = 3'b001;
    localparam logic [2:0] LEN_WORD = 3'b010;
    localparam int         LEN_SIGNED_BIT = 2;

    localparam int LINE_WORDS_DEFAULT = 4;

    // Byte address of word 'idx' in a line starting at 'base'; wraps mod 2^32.
    function automatic logic [31:0] line_word_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single memory controller between the instruction-fetch line
// filler (IF) and the load/store buffer (LSB). A granted LSB request is passed
// through as one controller transaction; a granted IF request is expanded into
// LINE_WORDS word reads. Every controller transaction is followed by one GAP
// cycle with mc_waiting low. All outputs are registered.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global stall), RoB_clear (flush)
//   if_req/if_addr                     : line fill request (line-aligned base)
//   if_word_valid/if_word_idx/if_word  : one returned fill word
//   if_done                            : pulsed with the last word of a line
//   lsb_req/lsb_wr/lsb_len/lsb_addr/lsb_value : load/store request
//   lsb_done/lsb_result                : load/store completion
//   mc_waiting/mc_wr/mc_len/mc_addr/mc_value  : controller request
//   mc_ready/mc_result                 : controller response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          RoB_clear,
    input  logic                          if_req,
    input  logic [31:0]                   if_addr,
    output logic                          if_word_valid,
    output logic [$clog2(LINE_WORDS)-1:0] if_word_idx,
    output logic [31:0]                   if_word,
    output logic                          if_done,
    input  logic                          lsb_req,
    input  logic                          lsb_wr,
    input  logic [2:0]                    lsb_len,
    input  logic [31:0]                   lsb_addr,
    input  logic [31:0]                   lsb_value,
    output logic                          lsb_done,
    output logic [31:0]                   lsb_result,
    output logic                          mc_waiting,
    output logic                          mc_wr,
    output logic [2:0]                    mc_len,
    output logic [31:0]                   mc_addr,
    output logic [31:0]                   mc_value,
    input  logic                          mc_ready,
    input  logic [31:0]                   mc_result
);

    localparam int               IDX_W    = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic             last_lsb_q, last_lsb_d;      // previous grant went to LSB
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [31:0]      base_q, base_d;
    logic             mc_waiting_q, mc_waiting_d;
    logic             mc_wr_q, mc_wr_d;
    logic [2:0]       mc_len_q, mc_len_d;
    logic [31:0]      mc_addr_q, mc_addr_d;
    logic [31:0]      mc_value_q, mc_value_d;
    logic             lsb_done_q, lsb_done_d;
    logic [31:0]      lsb_result_q, lsb_result_d;
    logic             if_word_valid_q, if_word_valid_d;
    logic [IDX_W-1:0] if_word_idx_q, if_word_idx_d;
    logic [31:0]      if_word_q, if_word_d;
    logic             if_done_q, if_done_d;
    logic [IDX_W-1:0] next_idx;

    always_comb begin
        state_d         = state_q;
        last_lsb_d      = last_lsb_q;
        word_idx_d      = word_idx_q;
        base_d          = base_q;
        mc_waiting_d    = mc_waiting_q;
        mc_wr_d         = mc_wr_q;
        mc_len_d        = mc_len_q;
        mc_addr_d       = mc_addr_q;
        mc_value_d      = mc_value_q;
        lsb_done_d      = lsb_done_q;
        lsb_result_d    = lsb_result_q;
        if_word_valid_d = if_word_valid_q;
        if_word_idx_d   = if_word_idx_q;
        if_word_d       = if_word_q;
        if_done_d       = if_done_q;
        next_idx        = word_idx_q + IDX_W'(1);

        // Flush beats the stall: a mispredict must abort even while frozen.
        if (RoB_clear) begin
            state_d         = ST_IDLE;
            word_idx_d      = '0;
            mc_waiting_d    = 1'b0;
            lsb_done_d      = 1'b0;
            if_word_valid_d = 1'b0;
            if_done_d       = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    lsb_done_d      = 1'b0;
                    if_word_valid_d = 1'b0;
                    if_done_d       = 1'b0;
                    // On contention LSB wins unless it also won last time.
                    if (lsb_req && (!if_req || !last_lsb_q)) begin
                        state_d      = ST_LSB;
                        last_lsb_d   = 1'b1;
                        mc_waiting_d = 1'b1;
                        mc_wr_d      = lsb_wr;
                        mc_len_d     = lsb_len;
                        mc_addr_d    = lsb_addr;
                        mc_value_d   = lsb_value;
                    end else if (if_req) begin
                        state_d      = ST_IF;
                        last_lsb_d   = 1'b0;
                        base_d       = if_addr;
                        word_idx_d   = '0;
                        mc_waiting_d = 1'b1;
                        mc_wr_d      = 1'b0;
                        mc_len_d     = LEN_WORD;
                        mc_addr_d    = if_addr;
                        mc_value_d   = '0;
                    end
                end
                ST_LSB: begin
                    if (mc_waiting_q && mc_ready) begin
                        state_d      = ST_GAP;
                        mc_waiting_d = 1'b0;
                        lsb_done_d   = 1'b1;
                        lsb_result_d = mc_result;
                    end
                end
                ST_IF: begin
                    if (mc_waiting_q && mc_ready) begin
                        state_d         = ST_GAP;
                        mc_waiting_d    = 1'b0;
                        if_word_valid_d = 1'b1;
                        if_word_idx_d   = word_idx_q;
                        if_word_d       = mc_result;
                        if_done_d       = (word_idx_q == LAST_IDX);
                    end
                end
                ST_GAP: begin
                    lsb_done_d      = 1'b0;
                    if_word_valid_d = 1'b0;
                    if_done_d       = 1'b0;
                    // A word-valid without done means this GAP sits inside a
                    // line fill, so the fill continues without re-arbitration.
                    if (if_word_valid_q && !if_done_q) begin
                        state_d      = ST_IF;
                        word_idx_d   = next_idx;
                        mc_waiting_d = 1'b1;
                        mc_wr_d      = 1'b0;
                        mc_len_d     = LEN_WORD;
                        mc_addr_d    = line_word_addr(base_q, 32'(next_idx));
                        mc_value_d   = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        word_idx_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= ST_IDLE;
            last_lsb_q      <= 1'b0;
            word_idx_q      <= '0;
            base_q          <= '0;
            mc_waiting_q    <= 1'b0;
            mc_wr_q         <= 1'b0;
            mc_len_q        <= 3'b000;
            mc_addr_q       <= '0;
            mc_value_q      <= '0;
            lsb_done_q      <= 1'b0;
            lsb_result_q    <= '0;
            if_word_valid_q <= 1'b0;
            if_word_idx_q   <= '0;
            if_word_q       <= '0;
            if_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_lsb_q      <= last_lsb_d;
            word_idx_q      <= word_idx_d;
            base_q          <= base_d;
            mc_waiting_q    <= mc_waiting_d;
            mc_wr_q         <= mc_wr_d;
            mc_len_q        <= mc_len_d;
            mc_addr_q       <= mc_addr_d;
            mc_value_q      <= mc_value_d;
            lsb_done_q      <= lsb_done_d;
            lsb_result_q    <= lsb_result_d;
            if_word_valid_q <= if_word_valid_d;
            if_word_idx_q   <= if_word_idx_d;
            if_word_q       <= if_word_d;
            if_done_q       <= if_done_d;
        end
    end

    assign mc_waiting    = mc_waiting_q;
    assign mc_wr         = mc_wr_q;
    assign mc_len        = mc_len_q;
    assign mc_addr       = mc_addr_q;
    assign mc_value      = mc_value_q;
    assign lsb_done      = lsb_done_q;
    assign lsb_result    = lsb_result_q;
    assign if_word_valid = if_word_valid_q;
    assign if_word_idx   = if_word_idx_q;
    assign if_word       = if_word_q;
    assign if_done       = if_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter (LINE_WORDS = 4). Each scenario task
// drives its stimulus and checks outputs one time unit after the rising edge.
// The memory controller is modelled by driving mc_ready/mc_result directly.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        RoB_clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_word_valid;
    logic [1:0]  if_word_idx;
    logic [31:0] if_word;
    logic        if_done;
    logic        lsb_req;
    logic        lsb_wr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_value;
    logic        lsb_done;
    logic [31:0] lsb_result;
    logic        mc_waiting;
    logic        mc_wr;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_value;
    logic        mc_ready;
    logic [31:0] mc_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [159:0] act, exp;

    mem_arbiter #(.LINE_WORDS(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .RoB_clear    (RoB_clear),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_word_valid(if_word_valid),
        .if_word_idx  (if_word_idx),
        .if_word      (if_word),
        .if_done      (if_done),
        .lsb_req      (lsb_req),
        .lsb_wr       (lsb_wr),
        .lsb_len      (lsb_len),
        .lsb_addr     (lsb_addr),
        .lsb_value    (lsb_value),
        .lsb_done     (lsb_done),
        .lsb_result   (lsb_result),
        .mc_waiting   (mc_waiting),
        .mc_wr        (mc_wr),
        .mc_len       (mc_len),
        .mc_addr      (mc_addr),
        .mc_value     (mc_value),
        .mc_ready     (mc_ready),
        .mc_result    (mc_result)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        tick;
        tick;
        act = 160'({mc_waiting, mc_wr, mc_len, mc_addr, mc_value, lsb_done, lsb_result,
                    if_word_valid, if_word_idx, if_word, if_done});
        exp = '0;
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", act, exp); end
        act = 160'(dut.state_q);
        exp = 160'(ST_IDLE);
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", act, exp); end
        rst_in = 1'b1;
        tick;
        // Last grant after reset is IF, so simultaneous requests go to LSB.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b010; lsb_addr = 32'h80; lsb_value = 32'h11;
        if_req = 1'b1; if_addr = 32'h7000;
        tick;
        act = 160'({mc_waiting, mc_wr, mc_addr});
        exp = 160'({1'b1, 1'b1, 32'h80});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL reset_last_grant: got %h expected %h", act, exp); end
        RoB_clear = 1'b1; lsb_req = 1'b0; if_req = 1'b0;
        tick;
        RoB_clear = 1'b0;
        act = 160'(mc_waiting);
        exp = 160'(1'b0);
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL reset_clear_abort: got %h expected %h", act, exp); end
    endtask

    task automatic test_lone_store;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b010; lsb_addr = 32'h100; lsb_value = 32'hDEADBEEF;
        tick;
        for (int i = 0; i < 4; i++) begin
            act = 160'({mc_waiting, mc_wr, mc_len, mc_addr, mc_value, lsb_done});
            exp = 160'({1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL store_req[%0d]: got %h expected %h", i, act, exp); end
            if (i == 3) begin mc_ready = 1'b1; mc_result = 32'hCAFE0001; end
            tick;
        end
        mc_ready = 1'b0; lsb_req = 1'b0;
        act = 160'({lsb_done, mc_waiting, lsb_result});
        exp = 160'({1'b1, 1'b0, 32'hCAFE0001});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL store_gap: got %h expected %h", act, exp); end
        for (int i = 0; i < 2; i++) begin
            tick;
            act = 160'({lsb_done, mc_waiting});
            exp = 160'({1'b0, 1'b0});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL store_after[%0d]: got %h expected %h", i, act, exp); end
        end
    endtask

    task automatic test_line_fill;
        if_req = 1'b1; if_addr = 32'h1000;
        tick;
        for (int w = 0; w < 4; w++) begin
            act = 160'({mc_waiting, mc_wr, mc_len, mc_addr, mc_value, if_word_valid});
            exp = 160'({1'b1, 1'b0, 3'b010, 32'h1000 + 32'(4 * w), 32'h0, 1'b0});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL fill_req[%0d]: got %h expected %h", w, act, exp); end
            mc_ready = 1'b1; mc_result = 32'hA000 + 32'(w);
            tick;
            mc_ready = 1'b0;
            if (w == 3) if_req = 1'b0;
            act = 160'({if_word_valid, if_word_idx, if_word, if_done, mc_waiting});
            exp = 160'({1'b1, 2'(w), 32'hA000 + 32'(w), (w == 3), 1'b0});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL fill_word[%0d]: got %h expected %h", w, act, exp); end
            tick;
        end
        act = 160'({mc_waiting, if_word_valid, if_done});
        exp = '0;
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL fill_end_idle: got %h expected %h", act, exp); end
    endtask

    task automatic test_contention;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b010; lsb_addr = 32'h200; lsb_value = 32'h22222222;
        if_req = 1'b1; if_addr = 32'h2000;
        tick;
        act = 160'({mc_waiting, mc_wr, mc_addr, mc_value});
        exp = 160'({1'b1, 1'b1, 32'h200, 32'h22222222});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_lsb_first: got %h expected %h", act, exp); end
        mc_ready = 1'b1; mc_result = 32'h0;
        tick;
        mc_ready = 1'b0; lsb_req = 1'b0;
        act = 160'({lsb_done, if_word_valid});
        exp = 160'({1'b1, 1'b0});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_lsb_done: got %h expected %h", act, exp); end
        tick;
        tick;
        act = 160'({mc_waiting, mc_wr, mc_addr});
        exp = 160'({1'b1, 1'b0, 32'h2000});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_if_second: got %h expected %h", act, exp); end
        // New load arrives mid-fill; it must wait until the line is finished.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'b100; lsb_addr = 32'h300; lsb_value = 32'h0;
        for (int w = 0; w < 4; w++) begin
            act = 160'({mc_waiting, mc_wr, mc_addr});
            exp = 160'({1'b1, 1'b0, 32'h2000 + 32'(4 * w)});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL cont_fill_req[%0d]: got %h expected %h", w, act, exp); end
            mc_ready = 1'b1; mc_result = 32'hB000 + 32'(w);
            tick;
            mc_ready = 1'b0;
            if (w == 3) if_req = 1'b0;
            act = 160'({if_word_valid, if_word_idx, if_done, lsb_done});
            exp = 160'({1'b1, 2'(w), (w == 3), 1'b0});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL cont_fill_word[%0d]: got %h expected %h", w, act, exp); end
            tick;
        end
        act = 160'(mc_waiting);
        exp = 160'(1'b0);
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_idle_gap: got %h expected %h", act, exp); end
        tick;
        act = 160'({mc_waiting, mc_wr, mc_len, mc_addr});
        exp = 160'({1'b1, 1'b0, 3'b100, 32'h300});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_lsb_after: got %h expected %h", act, exp); end
        mc_ready = 1'b1; mc_result = 32'h55;
        tick;
        mc_ready = 1'b0; lsb_req = 1'b0;
        act = 160'({lsb_done, lsb_result});
        exp = 160'({1'b1, 32'h55});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL cont_load_done: got %h expected %h", act, exp); end
        tick;
    endtask

    task automatic test_anti_starvation;
        // Last grant was the LSB load above, so IF wins this tie.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'b010; lsb_addr = 32'h400; lsb_value = 32'h1;
        if_req = 1'b1; if_addr = 32'h3000;
        tick;
        act = 160'({mc_waiting, mc_wr, mc_addr});
        exp = 160'({1'b1, 1'b0, 32'h3000});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL starve_if_wins: got %h expected %h", act, exp); end
        RoB_clear = 1'b1; lsb_req = 1'b0; if_req = 1'b0;
        tick;
        RoB_clear = 1'b0;
        act = 160'({mc_waiting, if_word_valid, if_done});
        exp = '0;
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL starve_clear: got %h expected %h", act, exp); end
    endtask

    task automatic test_flush;
        if_req = 1'b1; if_addr = 32'h4000;
        tick;
        for (int w = 0; w < 2; w++) begin
            act = 160'({mc_waiting, mc_addr});
            exp = 160'({1'b1, 32'h4000 + 32'(4 * w)});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL flush_req[%0d]: got %h expected %h", w, act, exp); end
            mc_ready = 1'b1; mc_result = 32'hC000 + 32'(w);
            tick;
            mc_ready = 1'b0;
            act = 160'({if_word_valid, if_word_idx});
            exp = 160'({1'b1, 2'(w)});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL flush_word[%0d]: got %h expected %h", w, act, exp); end
            if (w == 0) tick;
        end
        RoB_clear = 1'b1; if_req = 1'b0;
        tick;
        RoB_clear = 1'b0;
        act = 160'({mc_waiting, if_word_valid, if_done, dut.word_idx_q, dut.state_q});
        exp = 160'({1'b0, 1'b0, 1'b0, 2'b00, ST_IDLE});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL flush_idle: got %h expected %h", act, exp); end
        for (int i = 0; i < 3; i++) begin
            tick;
            act = 160'({mc_waiting, if_word_valid, if_done});
            exp = '0;
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL flush_quiet[%0d]: got %h expected %h", i, act, exp); end
        end
        if_req = 1'b1;
        tick;
        act = 160'({mc_waiting, mc_addr});
        exp = 160'({1'b1, 32'h4000});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL flush_reissue: got %h expected %h", act, exp); end
        mc_ready = 1'b1; mc_result = 32'hD000;
        tick;
        mc_ready = 1'b0;
        act = 160'({if_word_valid, if_word_idx, if_word});
        exp = 160'({1'b1, 2'd0, 32'hD000});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL flush_restart_idx: got %h expected %h", act, exp); end
        RoB_clear = 1'b1; if_req = 1'b0;
        tick;
        RoB_clear = 1'b0;
    endtask

    task automatic test_stall;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'b001; lsb_addr = 32'h500; lsb_value = 32'h0;
        tick;
        mc_ready = 1'b1; mc_result = 32'h1234;
        tick;
        mc_ready = 1'b0; lsb_req = 1'b0;
        act = 160'({lsb_done, lsb_result});
        exp = 160'({1'b1, 32'h1234});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL stall_done: got %h expected %h", act, exp); end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            act = 160'({lsb_done, lsb_result, mc_waiting, dut.state_q});
            exp = 160'({1'b1, 32'h1234, 1'b0, ST_GAP});
            n_checks++;
            if (act !== exp) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, act, exp); end
        end
        rdy_in = 1'b1;
        tick;
        act = 160'({lsb_done, dut.state_q});
        exp = 160'({1'b0, ST_IDLE});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL stall_release: got %h expected %h", act, exp); end
    endtask

    task automatic test_async_reset;
        if_req = 1'b1; if_addr = 32'h6000;
        tick;
        mc_ready = 1'b1; mc_result = 32'h77;
        tick;
        mc_ready = 1'b0;
        tick;
        act = 160'({mc_waiting, mc_addr});
        exp = 160'({1'b1, 32'h6004});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL areset_midfill: got %h expected %h", act, exp); end
        // Assert reset between edges and look before the next edge arrives.
        #2;
        rst_in = 1'b0;
        #1;
        act = 160'({mc_waiting, mc_wr, mc_len, mc_addr, mc_value, lsb_done, lsb_result,
                    if_word_valid, if_word_idx, if_word, if_done});
        exp = '0;
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL areset_outputs: got %h expected %h", act, exp); end
        act = 160'({dut.state_q, dut.word_idx_q});
        exp = 160'({ST_IDLE, 2'b00});
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL areset_state: got %h expected %h", act, exp); end
        if_req = 1'b0;
        #2;
        rst_in = 1'b1;
        tick;
        act = 160'(mc_waiting);
        exp = 160'(1'b0);
        n_checks++;
        if (act !== exp) begin n_fail++; $display("FAIL areset_after: got %h expected %h", act, exp); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; RoB_clear = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = '0; lsb_addr = '0; lsb_value = '0;
        mc_ready = 1'b0; mc_result = '0;
        test_reset;
        test_lone_store;
        test_line_fill;
        test_contention;
        test_anti_starvation;
        test_flush;
        test_stall;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, giving the words per instruction-line fill (power of two, 2..16).
REQ-002 SHALL have port clk_in, input, 1, the single clock.
REQ-003 SHALL have port rst_in, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1; when low, all registers hold.
REQ-005 SHALL have port RoB_clear, input, 1, the misprediction flush.
REQ-006 SHALL have port if_req, input, 1, the instruction-line fill request.
REQ-007 SHALL have port if_addr, input, 32, the line base address, aligned to 4*LINE_WORDS.
REQ-008 SHALL have ports if_word_valid (output, 1), if_word_idx (output, log2(LINE_WORDS)) and if_word (output, 32), which return one fill word.
REQ-009 SHALL have port if_done, output, 1, pulsed with the last word of a line.
REQ-010 SHALL have ports lsb_req (input, 1), lsb_wr (input, 1), lsb_len (input, 3, same encoding as mc_len), lsb_addr (input, 32) and lsb_value (input, 32), which carry the load/store request.
REQ-011 SHALL have ports lsb_done (output, 1) and lsb_result (output, 32), which complete a load/store.
REQ-012 SHALL have memory-controller request ports mc_waiting (output, 1), mc_wr (output, 1), mc_len (output, 3), mc_addr (output, 32) and mc_value (output, 32).
REQ-013 SHALL have memory-controller response ports mc_ready (input, 1) and mc_result (input, 32).

Function
REQ-014 SHALL implement states IDLE, LSB, IF and GAP; every output SHALL be registered.
REQ-015 SHALL sample requests only in IDLE.
REQ-016 SHALL grant LSB when only lsb_req is high, and IF when only if_req is high.
REQ-017 SHALL, when both requests are high in IDLE, grant LSB unless the previous grant was LSB, in which case it grants IF (anti-starvation).
REQ-018 SHALL, on an LSB grant, copy lsb_wr/len/addr/value to mc_* and assert mc_waiting, holding them stable until completion.
REQ-019 SHALL, on an IF grant, latch if_addr, clear word_idx, and drive mc_wr=0, mc_len=3'b010, mc_addr=base+4*word_idx, mc_value=0.
REQ-020 SHALL treat mc_waiting && mc_ready at a clock edge as completion.
REQ-021 SHALL, on completion in LSB, enter GAP, register mc_result into lsb_result, and pulse lsb_done for exactly the GAP cycle.
REQ-022 SHALL, on completion in IF, enter GAP and pulse if_word_valid with if_word=mc_result and if_word_idx=word_idx.
REQ-023 SHALL, on the IF completion where word_idx==LINE_WORDS-1, also pulse if_done in the same cycle.
REQ-024 SHALL hold mc_waiting low in GAP, so there is at least one idle cycle between controller transactions.
REQ-025 SHALL, from GAP, go to IF with word_idx+1 if line words remain, otherwise to IDLE.
REQ-026 SHALL NOT let an LSB request preempt a line fill between words.
REQ-027 SHALL, when RoB_clear is high at a clock edge (priority over rdy_in), enter IDLE, drop mc_waiting and all pulses, clear word_idx, and return no partial line.
REQ-028 SHALL rely on requesters holding req and arguments until done, then dropping req by the following cycle; a re-request is a new transaction.
REQ-029 SHALL, when rdy_in is low, freeze state, counters and outputs, including any high pulse.
REQ-030 SHALL compute line addresses modulo 2^32.

Reset
REQ-031 SHALL, while rst_in is low, set state=IDLE, last-grant=IF, word_idx=0, every output 0, and mc_len=0.

Structure
REQ-032 SHALL take the state encoding, the mc_len codes (byte 000, half 001, word 010, bit2=signed) and the LINE_WORDS default from a shared memory-interface package.
REQ-033 SHALL be a single module with no sub-module; the word counter and address adder are inline.

Verification
REQ-034 SHALL verify a lone store: lsb_wr=1, len=010, addr=0x100, value=0xDEADBEEF, with mc_ready after 4 cycles -> mc_* match for 4 cycles, lsb_done pulses once in GAP, mc_waiting drops for 1 cycle.
REQ-035 SHALL verify a line fill: if_addr=0x1000 with LINE_WORDS=4 -> mc_addr runs 0x1000, 0x1004, 0x1008, 0x100C; if_word_idx 0..3; if_done only with idx 3.
REQ-036 SHALL verify contention: lsb_req and if_req rise together with last-grant=IF -> LSB served first, then IF; a new lsb_req during the fill waits until if_done.
REQ-037 SHALL verify a flush: RoB_clear asserted after word 1 of a fill -> next cycle IDLE, mc_waiting=0, no if_done; a re-issued fill restarts at idx 0.
REQ-038 SHALL verify stall: rdy_in low for 3 cycles during lsb_done -> lsb_done stays high and state is unchanged, then the pulse ends one cycle after rdy_in returns.
REQ-039 SHALL verify asynchronous reset: rst_in low mid-fill, between clock edges -> outputs go to 0 immediately, with no clock edge required.
